// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Also holds the MMIO register map used by the IO block decode.
package uart_tx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // MMIO offsets and status register layout seen by software.
    localparam logic [7:0] IO_UART_TX_OFFSET   = 8'h00;
    localparam logic [7:0] IO_UART_STAT_OFFSET = 8'h04;
    localparam int         STAT_BUSY_BIT       = 0;
    localparam int         STAT_FULL_BIT       = 1;
    localparam int         STAT_EMPTY_BIT      = 2;
    localparam int         STAT_LEVEL_LSB      = 8;
    localparam int         STAT_LEVEL_MSB      = 15;

    function automatic logic parity_bit(input logic [7:0] data, input int nbits, input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < nbits) p = p ^ data[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake between the MMIO decode and the UART TX block.
interface uart_tx_fifo_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       flush;

    modport master (output wr_valid, output wr_data, output flush, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input flush, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Generic synchronous FIFO with flush; head word is read combinationally.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Flush takes priority over a same-cycle push; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: MMIO writes queue into a FIFO, a frame
// serialiser drains it onto uart_tx with configurable parity and stop bits.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter  int CLK_DIV    = 434,
    parameter  int DATA_BITS  = 8,
    parameter  int FIFO_DEPTH = 16,
    parameter  int PARITY_EN  = 0,
    parameter  int PARITY_ODD = 0,
    parameter  int STOP_BITS  = 1,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_fifo_if.slave      wr,
    output logic               fifo_full_o,
    output logic               fifo_empty_o,
    output logic [LVL_W-1:0]   fifo_level_o,
    output logic               busy_o,
    output logic               uart_tx_o
);

    localparam int                BAUD_W      = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);

    tx_state_e         state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
    logic              par_q;
    logic              tx_q;
    logic              busy_q;
    logic [7:0]        head;
    logic              push;
    logic              pop;
    logic              bit_done;
    logic              stop_done;

    assign wr.wr_ready = !fifo_full_o;
    assign push        = wr.wr_valid && !fifo_full_o && !wr.flush;
    assign bit_done    = (baud_q == '0);
    assign stop_done   = (state_q == ST_STOP) && bit_done && (bit_q == 3'(STOP_BITS - 1));
    // Popping at STOP expiry chains frames with no idle bit in between.
    assign pop         = !fifo_empty_o && ((state_q == ST_IDLE) || stop_done);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (wr.flush),
        .data_i  (wr.wr_data),
        .data_o  (head),
        .full_o  (fifo_full_o),
        .empty_o (fifo_empty_o),
        .level_o (fifo_level_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else if (pop) begin
            state_q <= ST_START;
            baud_q  <= BAUD_RELOAD;
            bit_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            shift_q <= head;
            par_q   <= parity_bit(head, DATA_BITS, PARITY_ODD != 0);
        end else if (state_q != ST_IDLE) begin
            if (!bit_done) begin
                baud_q <= baud_q - 1'b1;
            end else begin
                baud_q <= BAUD_RELOAD;
                case (state_q)
                    ST_START: begin
                        state_q <= ST_DATA;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                    ST_DATA: begin
                        if (bit_q == 3'(DATA_BITS - 1)) begin
                            bit_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q <= ST_PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                    ST_PARITY: begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
                    ST_STOP: begin
                        // Last stop bit with nothing queued: line is already high.
                        if (bit_q == 3'(STOP_BITS - 1)) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign uart_tx_o = tx_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: three instances (8N1, 8E2, 8O1),
// a line monitor decodes frames and compares them against queued expectations.
module tb_uart_tx_fifo;

    localparam int CLK_DIV = 4;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         b2b;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rst_cnt = 0;
    int   sel = 0;
    logic line;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst) rst_cnt <= rst_cnt + 1;

    uart_tx_fifo_if if_a ();
    uart_tx_fifo_if if_b ();
    uart_tx_fifo_if if_c ();

    logic full_a, empty_a, busy_a, tx_a;
    logic full_b, empty_b, busy_b, tx_b;
    logic full_c, empty_c, busy_c, tx_c;
    logic [2:0] lvl_a, lvl_b, lvl_c;

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .FIFO_DEPTH(4),
                   .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .wr(if_a.slave), .fifo_full_o(full_a), .fifo_empty_o(empty_a),
        .fifo_level_o(lvl_a), .busy_o(busy_a), .uart_tx_o(tx_a));

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .FIFO_DEPTH(4),
                   .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .wr(if_b.slave), .fifo_full_o(full_b), .fifo_empty_o(empty_b),
        .fifo_level_o(lvl_b), .busy_o(busy_b), .uart_tx_o(tx_b));

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .FIFO_DEPTH(4),
                   .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .wr(if_c.slave), .fifo_full_o(full_c), .fifo_empty_o(empty_c),
        .fifo_level_o(lvl_c), .busy_o(busy_c), .uart_tx_o(tx_c));

    always_comb begin
        case (sel)
            0:       line = tx_a;
            1:       line = tx_b;
            default: line = tx_c;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout/unexpected event, required none", name);
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] d, input logic f);
        case (s)
            0:       begin if_a.wr_valid = v; if_a.wr_data = d; if_a.flush = f; end
            1:       begin if_b.wr_valid = v; if_b.wr_data = d; if_b.flush = f; end
            default: begin if_c.wr_valid = v; if_c.wr_data = d; if_c.flush = f; end
        endcase
    endtask

    function automatic logic rdy(input int s);
        case (s)
            0:       return if_a.wr_ready;
            1:       return if_b.wr_ready;
            default: return if_c.wr_ready;
        endcase
    endfunction

    function automatic logic bsy(input int s);
        case (s)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    // Called just after a negedge; returns one negedge after the accepting edge.
    task automatic wr(input int s, input logic [7:0] d, input logic par, input bit b2b,
                      input bit expect_frame, output int stalls);
        exp_t e;
        stalls = 0;
        drive(s, 1'b1, d, 1'b0);
        while (!rdy(s) && stalls < 500) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 500) fail_now("wr_ready_timeout");
        else if (expect_frame) begin
            e.data = d;
            e.par  = par;
            e.b2b  = b2b;
            sb.push_back(e);
        end
        @(negedge clk);
        drive(s, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input int s);
        int n = 0;
        while (bsy(s) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail_now("busy_timeout");
        repeat (4) @(negedge clk);
    endtask

    task automatic busy_width(input int s, input int exp, input string name);
        int n = 0;
        int w = 0;
        while (!bsy(s) && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (bsy(s) && w < 500) begin
            @(negedge clk);
            w++;
        end
        check(name, w, exp);
    endtask

    initial begin : monitor
        logic [7:0] d;
        logic       st;
        logic       p;
        logic [1:0] sp;
        int         t0;
        int         r0;
        int         nstop;
        int         prev_start;
        bit         pen;
        exp_t       e;
        prev_start = -1000;
        forever begin
            @(negedge clk);
            if (line === 1'b0) begin
                t0    = cyc;
                r0    = rst_cnt;
                pen   = (sel != 0);
                nstop = (sel == 1) ? 2 : 1;
                @(negedge clk);
                st = line;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    d[i] = line;
                end
                p = 1'b0;
                if (pen) begin
                    repeat (CLK_DIV) @(negedge clk);
                    p = line;
                end
                sp = 2'b00;
                for (int i = 0; i < nstop; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    sp[i] = line;
                end
                if (rst_cnt == r0) begin
                    if (sb.size() == 0) begin
                        fail_now($sformatf("unexpected_frame_%02h", d));
                    end else begin
                        e = sb.pop_front();
                        check("start_bit", st, 0);
                        check("frame_data", d, e.data);
                        if (pen) check("parity_bit", p, e.par);
                        check("stop_bits", sp, (nstop == 2) ? 2'b11 : 2'b01);
                        if (e.b2b) check("frame_gap", t0 - prev_start,
                                         CLK_DIV * (1 + 8 + (pen ? 1 : 0) + nstop));
                    end
                end
                prev_start = t0;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got time limit, required completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : stim
        int         stalls;
        logic [7:0] d8;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        drive(2, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", tx_a, 1);
        check("rst_busy", busy_a, 0);
        check("rst_empty", empty_a, 1);
        check("rst_full", full_a, 0);
        check("rst_level", lvl_a, 0);
        check("rst_wr_ready", if_a.wr_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Single 8N1 frame of 0x55
        wr(0, 8'h55, 1'b0, 0, 1, stalls);
        check("lat_tx_before_pop", tx_a, 1);
        check("lat_level_queued", lvl_a, 1);
        @(negedge clk);
        check("lat_start_bit", tx_a, 0);
        check("lat_level_popped", lvl_a, 0);
        busy_width(0, 40, "busy_width_8n1");
        check("tx_idle_after_frame", tx_a, 1);
        wait_idle(0);

        // Fill and stall
        wr(0, 8'hA1, 1'b0, 0, 1, stalls);
        wr(0, 8'hB2, 1'b0, 1, 1, stalls);
        wr(0, 8'hC3, 1'b0, 1, 1, stalls);
        wr(0, 8'hD4, 1'b0, 1, 1, stalls);
        wr(0, 8'hE5, 1'b0, 1, 1, stalls);
        check("fill_full", full_a, 1);
        check("fill_level", lvl_a, 4);
        check("fill_wr_ready", if_a.wr_ready, 0);
        wr(0, 8'h36, 1'b0, 1, 1, stalls);
        check("stall_cycles", stalls, 37);
        wait_idle(0);

        // Ordering of 16 back-to-back bytes
        for (int i = 0; i < 16; i++) begin
            d8 = 8'(i * 17);
            wr(0, d8, 1'b0, (i != 0), 1, stalls);
        end
        wait_idle(0);

        // Parity: even with two stop bits, then odd with one
        sel = 1;
        wr(1, 8'h07, 1'b1, 0, 1, stalls);
        busy_width(1, 48, "busy_width_8e2");
        wait_idle(1);
        sel = 2;
        wr(2, 8'h07, 1'b0, 0, 1, stalls);
        busy_width(2, 44, "busy_width_8o1");
        wait_idle(2);
        sel = 0;

        // Flush during frame 1
        wr(0, 8'h5A, 1'b0, 0, 1, stalls);
        wr(0, 8'h3C, 1'b0, 0, 0, stalls);
        wr(0, 8'h99, 1'b0, 0, 0, stalls);
        check("flush_pre_level", lvl_a, 2);
        repeat (5) @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b0);
        check("flush_level", lvl_a, 0);
        check("flush_empty", empty_a, 1);
        check("flush_frame_continues", busy_a, 1);
        wait_idle(0);
        repeat (60) @(negedge clk);
        check("flush_no_more_frames", busy_a, 0);

        // Flush and push on the same edge
        drive(0, 1'b1, 8'hEE, 1'b1);
        check("flush_push_wr_ready", if_a.wr_ready, 1);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b0);
        check("flush_push_level", lvl_a, 0);
        check("flush_push_empty", empty_a, 1);
        repeat (60) @(negedge clk);
        check("flush_push_idle", busy_a, 0);

        // Reset during data bit 3 of 0x07
        wr(0, 8'h07, 1'b0, 0, 0, stalls);
        repeat (18) @(negedge clk);
        check("pre_rst_data_bit3", tx_a, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", tx_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_empty", empty_a, 1);
        check("midrst_level", lvl_a, 0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        wr(0, 8'hC5, 1'b0, 0, 1, stalls);
        busy_width(0, 40, "busy_width_after_rst");
        wait_idle(0);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
